// File: rtl/pla_restriction_sweeper.sv
// pla_restriction_sweeper
// Drives every input vector of a restricted PLA function (fixed bits held
// from a latched mask/value pair, free bits counted in ascending binary
// order) and records on-set size plus the first and last on-set vectors.
module pla_restriction_sweeper #(
    parameter int N_IN  = 14,
    parameter int CNT_W = N_IN + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_IN-1:0]  fix_mask,
    input  logic [N_IN-1:0]  fix_val,
    output logic [N_IN-1:0]  x_out,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] onset_count,
    output logic             onset_found,
    output logic [N_IN-1:0]  first_onset,
    output logic [N_IN-1:0]  last_onset
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [N_IN-1:0]  X_ONE   = N_IN'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state_q;
    logic [N_IN-1:0]   m_q;
    logic [N_IN-1:0]   v_q;
    logic [N_IN-1:0]   x_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              found_q;
    logic [N_IN-1:0]   first_q;
    logic [N_IN-1:0]   last_q;
    logic              busy_q;
    logic              done_q;

    logic [N_IN-1:0]   x_d;
    logic              last_vec_s;

    // Next vector in the sweep: fixed positions are forced to one so the
    // increment carries straight across them, then restored to their values.
    always_comb begin
        x_d        = (((x_q | m_q) + X_ONE) & ~m_q) | v_q;
        last_vec_s = &(x_q | m_q);
    end

    // Sweep controller: latches the restriction, steps one vector per clock
    // and accumulates the on-set statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            v_q     <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            first_q <= '0;
            last_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        m_q     <= fix_mask;
                        v_q     <= fix_val & fix_mask;
                        x_q     <= fix_val & fix_mask;
                        cnt_q   <= '0;
                        found_q <= 1'b0;
                        first_q <= '0;
                        last_q  <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= ST_SWEEP;
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_SWEEP: begin
                    if (y_in) begin
                        cnt_q  <= cnt_q + CNT_ONE;
                        last_q <= x_q;
                        if (!found_q) begin
                            first_q <= x_q;
                            found_q <= 1'b1;
                        end else begin
                            first_q <= first_q;
                        end
                    end else begin
                        cnt_q <= cnt_q;
                    end
                    if (last_vec_s) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        x_q     <= x_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign x_out       = x_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign onset_count = cnt_q;
    assign onset_found = found_q;
    assign first_onset = first_q;
    assign last_onset  = last_q;

endmodule
